// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: segment glyph constants and nibble decode shared by display blocks
// Segment bit order is bit6..bit0 = a,b,c,d,e,f,g, active-high.
package seven_segment_pkg;
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [15:0][6:0] GLYPHS = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                           SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    function automatic logic [6:0] decode_nibble(input logic [3:0] nibble, input logic hex_en);
        return (nibble > 4'd9 && !hex_en) ? SEG_BLANK : GLYPHS[nibble];
    endfunction
endpackage

// File: rtl/seven_segment_hex_decoder.sv
// seven_segment_hex_decoder: combinational nibble to a..g segment decode
// Ports: nibble_i - 4-bit value; seg_o - segments a..g (bit6..bit0), active-high.
// HEX_EN=0 leaves 10..15 dark instead of showing A..F.
module seven_segment_hex_decoder
    import seven_segment_pkg::*;
#(
    parameter bit HEX_EN = 1'b1
) (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = decode_nibble(nibble_i, HEX_EN);
endmodule

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: time-multiplexed N-digit seven-segment display driver
// Ports: clock/reset (async active-low); io_value packed nibbles (digit 0 rightmost);
// io_load captures io_value/io_dpIn/io_blankIn/io_lzb into shadows; io_enable runs the scan;
// io_segOut/io_dpOut/io_anOut/io_digitIdx are registered pin outputs.
module seven_segment_scan_driver
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int HEX_EN         = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0,
    localparam int DIGW          = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] io_value,
    input  logic                    io_load,
    input  logic [NUM_DIGITS-1:0]   io_dpIn,
    input  logic [NUM_DIGITS-1:0]   io_blankIn,
    input  logic                    io_lzb,
    input  logic                    io_enable,
    output logic [6:0]              io_segOut,
    output logic                    io_dpOut,
    output logic [NUM_DIGITS-1:0]   io_anOut,
    output logic [DIGW-1:0]         io_digitIdx
);
    localparam int   CNTW    = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic SEG_INV = SEG_ACTIVE_LOW != 0;
    localparam logic AN_INV  = AN_ACTIVE_LOW != 0;

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_q, blank_q, an_q, an_d, lz;
    logic                    lzb_q, dp_out_q, dp_out_d, wrap, dark;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [DIGW-1:0]         idx_q, idx_d, idx_out_q;
    logic [6:0]              seg_q, seg_d, glyph;
    logic [3:0]              nibble;

    assign nibble = value_q[4*idx_q +: 4];

    seven_segment_hex_decoder #(.HEX_EN(HEX_EN != 0)) u_dec (
        .nibble_i(nibble),
        .seg_o   (glyph)
    );

    // lz[k]: digits NUM_DIGITS-1 down to k are all zero
    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = value_q[4*NUM_DIGITS-1 -: 4] == 4'd0;
        for (int k = NUM_DIGITS - 2; k >= 0; k--) lz[k] = lz[k+1] && value_q[4*k +: 4] == 4'd0;
    end

    always_comb begin
        wrap     = cnt_q == CNTW'(REFRESH_DIV - 1);
        dark     = blank_q[idx_q] || (lzb_q && lz[idx_q] && idx_q != '0);
        cnt_d    = io_enable ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        idx_d    = (io_enable && wrap) ? (idx_q == DIGW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
        seg_d    = ((io_enable && !dark) ? glyph : SEG_BLANK) ^ {7{SEG_INV}};
        dp_out_d = (io_enable && !dark && dp_q[idx_q]) ^ SEG_INV;
        // anodes stay off for the first BLANK_CYCLES of each slot to avoid ghosting
        an_d     = ((io_enable && int'(cnt_q) >= BLANK_CYCLES) ? NUM_DIGITS'(1) << idx_q : '0)
                   ^ {NUM_DIGITS{AN_INV}};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q   <= '0;
            dp_q      <= '0;
            blank_q   <= '0;
            lzb_q     <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            idx_out_q <= '0;
            seg_q     <= {7{SEG_INV}};
            dp_out_q  <= SEG_INV;
            an_q      <= {NUM_DIGITS{AN_INV}};
        end else begin
            if (io_load) begin
                value_q <= io_value;
                dp_q    <= io_dpIn;
                blank_q <= io_blankIn;
                lzb_q   <= io_lzb;
            end
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            idx_out_q <= idx_q;
            seg_q     <= seg_d;
            dp_out_q  <= dp_out_d;
            an_q      <= an_d;
        end
    end

    assign io_segOut   = seg_q;
    assign io_dpOut    = dp_out_q;
    assign io_anOut    = an_q;
    assign io_digitIdx = idx_out_q;
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb_seven_segment_scan_driver: directed self-checking bench for seven_segment_scan_driver
module tb_seven_segment_scan_driver;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] io_value = '0;
    logic        io_load = 1'b0;
    logic [3:0]  io_dpIn = '0;
    logic [3:0]  io_blankIn = '0;
    logic        io_lzb = 1'b0;
    logic        io_enable = 1'b0;
    logic [6:0]  seg, seg_nh, seg_inv;
    logic        dp, dp_nh, dp_inv;
    logic [3:0]  an, an_nh, an_inv;
    logic [1:0]  idx, idx_nh, idx_inv;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    seven_segment_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_EN(1),
                                .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
        .clock(clock), .reset(reset), .io_value(io_value), .io_load(io_load), .io_dpIn(io_dpIn),
        .io_blankIn(io_blankIn), .io_lzb(io_lzb), .io_enable(io_enable),
        .io_segOut(seg), .io_dpOut(dp), .io_anOut(an), .io_digitIdx(idx));

    seven_segment_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_EN(0),
                                .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_nohex (
        .clock(clock), .reset(reset), .io_value(io_value), .io_load(io_load), .io_dpIn(io_dpIn),
        .io_blankIn(io_blankIn), .io_lzb(io_lzb), .io_enable(io_enable),
        .io_segOut(seg_nh), .io_dpOut(dp_nh), .io_anOut(an_nh), .io_digitIdx(idx_nh));

    seven_segment_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_EN(1),
                                .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_inv (
        .clock(clock), .reset(reset), .io_value(io_value), .io_load(io_load), .io_dpIn(io_dpIn),
        .io_blankIn(io_blankIn), .io_lzb(io_lzb), .io_enable(io_enable),
        .io_segOut(seg_inv), .io_dpOut(dp_inv), .io_anOut(an_inv), .io_digitIdx(idx_inv));

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // loads shadows with the scan frozen, then enables; scan state must be count 0, digit 0
    task automatic load_and_start(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] blv,
                                  input logic lz);
        io_enable = 1'b0;
        io_load = 1'b1;
        io_value = v;
        io_dpIn = dpv;
        io_blankIn = blv;
        io_lzb = lz;
        step(1);
        io_load = 1'b0;
        io_enable = 1'b1;
    endtask

    task automatic test_reset;
        step(2);
        n_cmp += 7;
        if (an !== 4'h0) begin n_err++; $display("FAIL reset_an got %b want 0000", an); end
        if (seg !== 7'h00) begin n_err++; $display("FAIL reset_seg got %h want 00", seg); end
        if (dp !== 1'b0) begin n_err++; $display("FAIL reset_dp got %b want 0", dp); end
        if (idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", idx); end
        if (seg_inv !== 7'h7F) begin n_err++; $display("FAIL reset_seg_inv got %h want 7f", seg_inv); end
        if (an_inv !== 4'hF) begin n_err++; $display("FAIL reset_an_inv got %b want 1111", an_inv); end
        if (dp_inv !== 1'b1) begin n_err++; $display("FAIL reset_dp_inv got %b want 1", dp_inv); end
        reset = 1'b1;
    endtask

    task automatic test_scan;
        logic [6:0] es [4] = '{7'h33, 7'h79, 7'h6D, 7'h30};
        logic [3:0] ea;
        load_and_start(16'h1234, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1);
            ea = (k % 4 == 0) ? 4'b0000 : 4'b0001 << (k / 4);
            n_cmp += 6;
            if (an !== ea) begin n_err++; $display("FAIL scan_an k=%0d got %b want %b", k, an, ea); end
            if (seg !== es[k/4]) begin n_err++; $display("FAIL scan_seg k=%0d got %h want %h", k, seg, es[k/4]); end
            if (idx !== 2'(k / 4)) begin n_err++; $display("FAIL scan_idx k=%0d got %0d want %0d", k, idx, k / 4); end
            if (an_inv !== ~ea) begin n_err++; $display("FAIL scan_an_inv k=%0d got %b want %b", k, an_inv, ~ea); end
            if (an_nh !== ea) begin n_err++; $display("FAIL scan_an_nohex k=%0d got %b want %b", k, an_nh, ea); end
            if (idx_inv !== 2'(k / 4)) begin n_err++; $display("FAIL scan_idx_inv k=%0d got %0d want %0d", k, idx_inv, k / 4); end
        end
    endtask

    task automatic test_lzb_hex;
        logic [6:0] es [4] = '{7'h7E, 7'h77, 7'h00, 7'h00};
        logic [6:0] en [4] = '{7'h7E, 7'h00, 7'h00, 7'h00};
        logic [3:0] ea;
        load_and_start(16'h00A0, 4'b0000, 4'b0000, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step(1);
            ea = (k % 4 == 0) ? 4'b0000 : 4'b0001 << (k / 4);
            n_cmp += 4;
            if (seg !== es[k/4]) begin n_err++; $display("FAIL lzb_seg k=%0d got %h want %h", k, seg, es[k/4]); end
            if (seg_nh !== en[k/4]) begin n_err++; $display("FAIL lzb_seg_nohex k=%0d got %h want %h", k, seg_nh, en[k/4]); end
            if (an !== ea) begin n_err++; $display("FAIL lzb_an k=%0d got %b want %b", k, an, ea); end
            if (dp_nh !== 1'b0) begin n_err++; $display("FAIL lzb_dp_nohex k=%0d got %b want 0", k, dp_nh); end
        end
    endtask

    task automatic test_lzb_dp;
        logic [6:0] es [4] = '{7'h7E, 7'h00, 7'h00, 7'h00};
        logic       ed [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] ea;
        load_and_start(16'h0000, 4'b0101, 4'b0000, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step(1);
            ea = (k % 4 == 0) ? 4'b0000 : 4'b0001 << (k / 4);
            n_cmp += 3;
            if (seg !== es[k/4]) begin n_err++; $display("FAIL lzdp_seg k=%0d got %h want %h", k, seg, es[k/4]); end
            if (dp !== ed[k/4]) begin n_err++; $display("FAIL lzdp_dp k=%0d got %b want %b", k, dp, ed[k/4]); end
            if (an !== ea) begin n_err++; $display("FAIL lzdp_an k=%0d got %b want %b", k, an, ea); end
        end
    endtask

    task automatic test_blank;
        logic [6:0] es [4] = '{7'h33, 7'h00, 7'h6D, 7'h30};
        logic       ed [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        load_and_start(16'h1234, 4'b1111, 4'b0010, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1);
            n_cmp += 2;
            if (seg !== es[k/4]) begin n_err++; $display("FAIL blank_seg k=%0d got %h want %h", k, seg, es[k/4]); end
            if (dp !== ed[k/4]) begin n_err++; $display("FAIL blank_dp k=%0d got %b want %b", k, dp, ed[k/4]); end
        end
    endtask

    task automatic test_active_low;
        logic [6:0] es [4] = '{7'h00, 7'h01, 7'h01, 7'h01};
        logic [3:0] ea;
        load_and_start(16'h0008, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1);
            ea = (k % 4 == 0) ? 4'b1111 : ~(4'b0001 << (k / 4));
            n_cmp += 3;
            if (seg_inv !== es[k/4]) begin n_err++; $display("FAIL inv_seg k=%0d got %h want %h", k, seg_inv, es[k/4]); end
            if (an_inv !== ea) begin n_err++; $display("FAIL inv_an k=%0d got %b want %b", k, an_inv, ea); end
            if (dp_inv !== 1'b1) begin n_err++; $display("FAIL inv_dp k=%0d got %b want 1", k, dp_inv); end
        end
    endtask

    task automatic test_enable_freeze;
        logic [3:0] ea [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b1000};
        logic [6:0] es [4] = '{7'h6D, 7'h6D, 7'h30, 7'h30};
        logic [1:0] ei [4] = '{2'd2, 2'd2, 2'd3, 2'd3};
        load_and_start(16'h1234, 4'b0000, 4'b0000, 1'b0);
        step(10);
        n_cmp += 2;
        if (an !== 4'b0100) begin n_err++; $display("FAIL freeze_pre_an got %b want 0100", an); end
        if (idx !== 2'd2) begin n_err++; $display("FAIL freeze_pre_idx got %0d want 2", idx); end
        io_enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            n_cmp += 5;
            if (an !== 4'b0000) begin n_err++; $display("FAIL freeze_an k=%0d got %b want 0000", k, an); end
            if (seg !== 7'h00) begin n_err++; $display("FAIL freeze_seg k=%0d got %h want 00", k, seg); end
            if (dp !== 1'b0) begin n_err++; $display("FAIL freeze_dp k=%0d got %b want 0", k, dp); end
            if (idx !== 2'd2) begin n_err++; $display("FAIL freeze_idx k=%0d got %0d want 2", k, idx); end
            if (an_inv !== 4'b1111) begin n_err++; $display("FAIL freeze_an_inv k=%0d got %b want 1111", k, an_inv); end
        end
        io_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            n_cmp += 3;
            if (an !== ea[k]) begin n_err++; $display("FAIL resume_an k=%0d got %b want %b", k, an, ea[k]); end
            if (seg !== es[k]) begin n_err++; $display("FAIL resume_seg k=%0d got %h want %h", k, seg, es[k]); end
            if (idx !== ei[k]) begin n_err++; $display("FAIL resume_idx k=%0d got %0d want %0d", k, idx, ei[k]); end
        end
        step(2);
    endtask

    task automatic test_reset_mid;
        load_and_start(16'h1234, 4'b0000, 4'b0000, 1'b0);
        step(14);
        n_cmp += 2;
        if (an !== 4'b1000) begin n_err++; $display("FAIL rstmid_pre_an got %b want 1000", an); end
        if (idx !== 2'd3) begin n_err++; $display("FAIL rstmid_pre_idx got %0d want 3", idx); end
        reset = 1'b0;
        #2;
        n_cmp += 5;
        if (an !== 4'b0000) begin n_err++; $display("FAIL rstmid_an got %b want 0000", an); end
        if (seg !== 7'h00) begin n_err++; $display("FAIL rstmid_seg got %h want 00", seg); end
        if (idx !== 2'd0) begin n_err++; $display("FAIL rstmid_idx got %0d want 0", idx); end
        if (an_inv !== 4'b1111) begin n_err++; $display("FAIL rstmid_an_inv got %b want 1111", an_inv); end
        if (seg_inv !== 7'h7F) begin n_err++; $display("FAIL rstmid_seg_inv got %h want 7f", seg_inv); end
        #2;
        reset = 1'b1;
        step(1);
        n_cmp += 3;
        if (an !== 4'b0000) begin n_err++; $display("FAIL rstrel_c1_an got %b want 0000", an); end
        if (seg !== 7'h7E) begin n_err++; $display("FAIL rstrel_c1_seg got %h want 7e", seg); end
        if (idx !== 2'd0) begin n_err++; $display("FAIL rstrel_c1_idx got %0d want 0", idx); end
        step(1);
        n_cmp += 2;
        if (an !== 4'b0001) begin n_err++; $display("FAIL rstrel_c2_an got %b want 0001", an); end
        if (idx !== 2'd0) begin n_err++; $display("FAIL rstrel_c2_idx got %0d want 0", idx); end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_lzb_hex;
        test_lzb_dp;
        test_blank;
        test_active_low;
        test_enable_freeze;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
